// File: rtl/conv_accumulator.sv
// Accumulates one kernel window of signed products plus bias, then applies optional
// ReLU, round-half-up requantisation and saturation to produce one activation per window.
module conv_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int TAPS   = 9,
    parameter int SHIFT  = 4,
    parameter int OUT_W  = 8,
    localparam int CNT_W = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic [15:0]       bias,
    input  logic              relu_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  tap_cnt
);

    // Handshake: a transfer happens on a side only in a cycle where both valid and
    // ready are high; valid never waits on ready, and a held result stays stable
    // until out_ready is seen.
    typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic signed [ACC_W:0] RND =
        (SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [ACC_W:0] MAX_OUT = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] MIN_OUT = -MAX_OUT - (ACC_W+1)'(1);

    state_t state_q, state_d;
    logic [ACC_W-1:0] acc;
    logic in_xfer, last_tap;
    logic [ACC_W-1:0] prod_ext, bias_ext, acc_base, sum;
    logic signed [ACC_W:0] v, rounded;
    logic [OUT_W-1:0] sat_data;

    always_comb begin
        in_ready = (state_q == ACCUM) || (state_q == HOLD && out_ready);
        in_xfer  = in_valid && in_ready;
        last_tap = (tap_cnt == CNT_W'(TAPS - 1));
        prod_ext = {{(ACC_W-PROD_W){in_product[PROD_W-1]}}, in_product};
        bias_ext = {{(ACC_W-16){bias[15]}}, bias};
        acc_base = (tap_cnt == '0) ? bias_ext : acc;
        sum      = acc_base + prod_ext;
    end

    // One guard bit above ACC_W keeps the rounding add from wrapping.
    always_comb begin
        v        = (relu_en && sum[ACC_W-1]) ? '0 : {sum[ACC_W-1], sum};
        rounded  = (v + RND) >>> SHIFT;
        sat_data = rounded[OUT_W-1:0];
        if (rounded > MAX_OUT) begin
            sat_data = MAX_OUT[OUT_W-1:0];
        end else if (rounded < MIN_OUT) begin
            sat_data = MIN_OUT[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (in_xfer && last_tap) state_d = HOLD;
                HOLD:    if (out_ready) state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // In HOLD tap_cnt is 0, so a same-cycle input transfer is always a tap 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_acc   <= '0;
        end else if (clear) begin
            tap_cnt   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state_q == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_xfer) begin
                if (last_tap) begin
                    out_acc   <= sum;
                    out_data  <= sat_data;
                    out_valid <= 1'b1;
                    tap_cnt   <= '0;
                end else begin
                    acc     <= sum;
                    tap_cnt <= tap_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench for conv_accumulator: windows with hand-computed sums, requant,
// ReLU, backpressure, clear and asynchronous reset.
module tb_conv_accumulator;

    localparam int TAPS = 9;

    logic clk = 1'b0;
    logic rst, clear, in_valid, relu_en, out_ready;
    logic in_ready, out_valid;
    logic [15:0] in_product, bias;
    logic signed [7:0]  out_data;
    logic signed [23:0] out_acc;
    logic [3:0] tap_cnt;

    int tests = 0;
    int errors = 0;

    conv_accumulator dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
        .bias(bias), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_acc(out_acc), .tap_cnt(tap_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
    endtask

    // Product of tap k is base + step*k; off-tap bias and relu_en carry junk.
    task automatic send_taps(input int base, input int step, input int bias_v,
                             input bit relu, input int from, input int to);
        for (int k = from; k < to; k++) begin
            in_valid   = 1'b1;
            in_product = 16'(base + step * k);
            bias       = (k == 0) ? 16'(bias_v) : 16'h7abc;
            relu_en    = (k == TAPS - 1) ? relu : ~relu;
            wait_ready();
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int exp_acc, input int exp_data);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_acc"}, 32'(out_acc), exp_acc);
        check({tag, "_data"}, 32'(out_data), exp_data);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drain"}, 32'(out_valid), 0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
        in_product = '0; bias = '0;
        #2;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_acc", 32'(out_acc), 0);
        check("rst_tap", 32'(tap_cnt), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: saturation high, latency
        send_taps(10000, 0, 0, 1'b0, 0, 8);
        check("t1_pre_valid", 32'(out_valid), 0);
        check("t1_tap8", 32'(tap_cnt), 8);
        send_taps(10000, 0, 0, 1'b0, 8, 9);
        check("t1_tap_wrap", 32'(tap_cnt), 0);
        expect_result("t1", 90000, 127);

        // 2: rounding
        send_taps(1, 1, 11, 1'b0, 0, 9);
        expect_result("t2a", 56, 4);
        send_taps(1, 1, 3, 1'b0, 0, 9);
        expect_result("t2b", 48, 3);

        // 3: saturation low and ReLU
        send_taps(-1000, 0, 0, 1'b0, 0, 9);
        expect_result("t3a", -9000, -128);
        send_taps(-1000, 0, 0, 1'b1, 0, 9);
        expect_result("t3b", -9000, 0);

        // round half up on negative sums
        send_taps(0, 0, -8, 1'b0, 0, 9);
        expect_result("rnd_m8", -8, 0);
        send_taps(0, 0, -9, 1'b0, 0, 9);
        expect_result("rnd_m9", -9, -1);
        send_taps(0, 0, 24, 1'b0, 0, 9);
        expect_result("rnd_24", 24, 2);

        // 4: backpressure then zero-bubble handoff
        send_taps(1, 1, 11, 1'b0, 0, 9);
        in_valid = 1'b1; in_product = 16'd100; bias = 16'd0; relu_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_data", 32'(out_data), 4);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 1);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_drain", 32'(out_valid), 0);
        check("bp_tap0_taken", 32'(tap_cnt), 1);
        send_taps(100, 0, 0, 1'b0, 1, 9);
        expect_result("t4", 900, 56);

        // 5: clear mid-window beats a simultaneous transfer
        send_taps(1000, 0, 500, 1'b0, 0, 4);
        check("t5_tap4", 32'(tap_cnt), 4);
        clear = 1'b1; in_valid = 1'b1; in_product = 16'd5000;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        check("t5_clear_tap", 32'(tap_cnt), 0);
        send_taps(1, 0, 0, 1'b0, 0, 9);
        expect_result("t5", 9, 1);

        // clear while holding discards the result
        send_taps(1, 0, 0, 1'b0, 0, 9);
        check("clr_hold_valid", 32'(out_valid), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_hold_drop", 32'(out_valid), 0);
        check("clr_hold_ready", 32'(in_ready), 1);

        // 6: asynchronous reset mid-window and in HOLD
        send_taps(7, 0, 0, 1'b0, 0, 5);
        check("t6_tap5", 32'(tap_cnt), 5);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_tap", 32'(tap_cnt), 0);
        check("t6_rst_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        send_taps(1000, 0, 0, 1'b0, 0, 9);
        check("t6_hold_valid", 32'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_hold_valid", 32'(out_valid), 0);
        check("t6_rst_hold_data", 32'(out_data), 0);
        check("t6_rst_hold_acc", 32'(out_acc), 0);
        @(negedge clk);
        rst = 1'b0;
        send_taps(1, 0, 0, 1'b0, 0, 9);
        expect_result("t6_after", 9, 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
